// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
// Holds the receiver state encoding, the bit-period counter width and the
// default bit period (clock cycles per serial bit).
package uart_pkg;

  localparam int CNT_W                = 12;
  localparam int DEFAULT_CLKS_PER_BIT = 87;

  // S_PARITY is only reachable when UART_RX_PARITY_EN is defined.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } uart_state_t;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: generic two-flop synchroniser for an asynchronous input pin.
// RST_VAL selects the value both flops take on reset, so an idle-high line
// does not look like an edge when reset is released.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous pin.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a valid/ready byte output.
// Optional feature macro: UART_RX_PARITY_EN (frame becomes 8E1 and
// parity_err reports mismatches; undefined means no parity bit and
// parity_err tied low).
//
// Handshake: rx_valid rises when a byte is loaded into rx_data and stays
// high, with rx_data stable, until an edge where rx_valid & rx_ready; a
// byte completing on that same edge keeps rx_valid high with the new data.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       parity_err
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic              w_rx_s;
  uart_state_t       r_state;
  uart_state_t       w_state_nxt;
  logic [CNT_W-1:0]  r_clk_cnt;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shreg;
  logic [7:0]        r_rx_data;
  logic              r_rx_valid;
  logic              r_frame_err;
  logic              r_overrun_err;

  logic              w_cnt_clr;
  logic              w_cnt_inc;
  logic              w_idx_clr;
  logic              w_sample_data;
  logic              w_load;
  logic              w_frame;
  logic              w_cnt_last;
  logic              w_cnt_half;

`ifdef UART_RX_PARITY_EN
  logic              w_sample_par;
  logic              w_stop_dec;
  logic              r_par_bit;
  logic              r_parity_err;
`endif

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .i_d     (rx),
    .o_q     (w_rx_s)
  );

  assign w_cnt_last = (r_clk_cnt == C_LAST);
  assign w_cnt_half = (r_clk_cnt == C_HALF);

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode and per-cycle datapath controls.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_clr     = 1'b0;
    w_cnt_inc     = 1'b0;
    w_idx_clr     = 1'b0;
    w_sample_data = 1'b0;
    w_load        = 1'b0;
    w_frame       = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_sample_par  = 1'b0;
    w_stop_dec    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt_clr = 1'b1;
        w_idx_clr = 1'b1;
        if (!w_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        // Re-check the line at the middle of the start bit to reject glitches.
        if (w_cnt_half) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_DATA: begin
        if (w_cnt_last) begin
          w_cnt_clr     = 1'b1;
          w_sample_data = 1'b1;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_cnt_last) begin
          w_cnt_clr    = 1'b1;
          w_sample_par = 1'b1;
          w_state_nxt  = S_STOP;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_cnt_last) begin
          w_cnt_clr = 1'b1;
`ifdef UART_RX_PARITY_EN
          w_stop_dec = 1'b1;
`endif
          if (w_rx_s) begin
            w_load      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_frame     = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_BREAK: begin
        // A held-low line reports one frame error, then waits for idle.
        w_cnt_clr = 1'b1;
        if (w_rx_s) w_state_nxt = S_IDLE;
      end
      default: begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Counters, shift register, output byte, handshake and error pulses.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_clk_cnt     <= '0;
      r_bit_idx     <= '0;
      r_shreg       <= '0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      if (w_cnt_clr)      r_clk_cnt <= '0;
      else if (w_cnt_inc) r_clk_cnt <= r_clk_cnt + C_ONE;

      if (w_idx_clr)          r_bit_idx <= '0;
      else if (w_sample_data) r_bit_idx <= r_bit_idx + 3'd1;

      if (w_sample_data) r_shreg[r_bit_idx] <= w_rx_s;

      if (w_load) r_rx_data <= r_shreg;

      // A load wins over an acceptance on the same edge.
      if (w_load)                        r_rx_valid <= 1'b1;
      else if (r_rx_valid && rx_ready)   r_rx_valid <= 1'b0;

      r_frame_err   <= w_frame;
      r_overrun_err <= w_load & r_rx_valid & ~rx_ready;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: parity bit XOR data bits must be zero at the stop decision.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_sample_par) r_par_bit <= w_rx_s;
      r_parity_err <= w_stop_dec & (r_par_bit ^ (^r_shreg));
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;

endmodule
